muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit for the MIPS datapath. It implements MULT, MULTU, DIV, DIVU and the HI/LO register pair, including MTHI/MTLO writes. It sits beside the ALU. The controller starts an operation and stalls on busy. The datapath reads hi/lo for MFHI/MFLO.

---
 rtl/muldiv_unit.sv | 183 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO register pair.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, sign-fixed at the end.
module muldiv_unit #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [Width-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [Width-1:0] hi_o,
  output logic [Width-1:0] lo_o
);

  localparam int unsigned CntW  = $clog2(Width);
  localparam int unsigned ProdW = 2 * Width;

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dbz_pend_q, dbz_pend_d;
  logic [Width-1:0] b_q, b_d;
  logic [Width-1:0] work_hi_q, work_hi_d;
  logic [Width-1:0] work_lo_q, work_lo_d;
  logic [Width-1:0] hi_q, hi_d;
  logic [Width-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             is_signed, a_neg, b_neg;
  logic [Width-1:0] a_mag, b_mag;
  logic [Width:0]   mul_sum, div_shift;
  logic [Width+1:0] div_diff;
  logic             div_ok;
  logic [ProdW-1:0] prod, prod_fix;
  logic [Width-1:0] quo_fix, rem_fix;

  // Datapath: operand magnitudes, one iteration step, and final sign correction.
  always_comb begin
    is_signed = ~op_i[0];
    a_neg     = is_signed & a_i[Width-1];
    b_neg     = is_signed & b_i[Width-1];
    a_mag     = a_neg ? (~a_i + Width'(1)) : a_i;
    b_mag     = b_neg ? (~b_i + Width'(1)) : b_i;

    mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, b_q} : '0);
    // Partial remainder shifted left with the next dividend bit; a borrow means restore.
    div_shift = {work_hi_q, work_lo_q[Width-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, b_q};
    div_ok    = ~div_diff[Width+1];

    prod      = {work_hi_q, work_lo_q};
    prod_fix  = neg_q ? (~prod + ProdW'(1)) : prod;
    quo_fix   = neg_q ? (~work_lo_q + Width'(1)) : work_lo_q;
    rem_fix   = neg_rem_q ? (~work_hi_q + Width'(1)) : work_hi_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    dbz_pend_d = dbz_pend_q;
    b_d        = b_q;
    work_hi_d  = work_hi_q;
    work_lo_d  = work_lo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dbz_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          is_div_d  = op_i[1];
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = op_i[1] & a_neg;
          b_d       = b_mag;
          cnt_d     = CntW'(Width - 1);
          if (op_i[1] && (b_i == '0)) begin
            // Divide by zero: preload the final values and let FIN pass them through.
            work_hi_d  = a_i;
            work_lo_d  = '1;
            neg_d      = 1'b0;
            neg_rem_d  = 1'b0;
            dbz_pend_d = 1'b1;
            state_d    = StFin;
          end else begin
            work_hi_d  = '0;
            work_lo_d  = a_mag;
            dbz_pend_d = 1'b0;
            state_d    = StRun;
          end
        end else begin
          if (hi_we_i) hi_d = wdata_i;
          if (lo_we_i) lo_d = wdata_i;
        end
      end
      StRun: begin
        if (is_div_q) begin
          work_hi_d = div_ok ? div_diff[Width-1:0] : div_shift[Width-1:0];
          work_lo_d = {work_lo_q[Width-2:0], div_ok};
        end else begin
          work_hi_d = mul_sum[Width:1];
          work_lo_d = {mul_sum[0], work_lo_q[Width-1:1]};
        end
        if (cnt_q == '0) begin
          state_d = StFin;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StFin: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        dbz_d   = dbz_pend_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_pend_q <= 1'b0;
      b_q        <= '0;
      work_hi_q  <= '0;
      work_lo_q  <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
      dbz_pend_q <= dbz_pend_d;
      b_q        <= b_d;
      work_hi_q  <= work_hi_d;
      work_lo_q  <= work_lo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign div_by_zero_o = dbz_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at Width=32 and Width=8.
module tb_muldiv_unit;

  localparam logic [1:0] OpMult  = 2'b00;
  localparam logic [1:0] OpMultu = 2'b01;
  localparam logic [1:0] OpDiv   = 2'b10;
  localparam logic [1:0] OpDivu  = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  logic        start8 = 1'b0;
  logic [1:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, dbz8;
  logic [7:0]  hi8, lo8;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {div_by_zero, hi, lo}
  logic [64:0] q32[$];
  logic [16:0] q8[$];

  always #5 clk = ~clk;

  muldiv_unit #(.Width(32)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .hi_we_i(hi_we), .lo_we_i(lo_we), .wdata_i(wdata), .busy_o(busy), .done_o(done),
    .div_by_zero_o(dbz), .hi_o(hi), .lo_o(lo)
  );

  muldiv_unit #(.Width(8)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .op_i(op8), .a_i(a8), .b_i(b8),
    .hi_we_i(1'b0), .lo_we_i(1'b0), .wdata_i(8'h00), .busy_o(busy8), .done_o(done8),
    .div_by_zero_o(dbz8), .hi_o(hi8), .lo_o(lo8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && dbz && !done) check("dbz32 without done", 64'(dbz), 64'(done));
    if (rst_n && done) begin
      if (q32.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL done32 unexpected: hi=0x%0h lo=0x%0h", hi, lo);
      end else begin
        logic [64:0] e;
        e = q32.pop_front();
        check("hi32", 64'(hi), 64'(e[63:32]));
        check("lo32", 64'(lo), 64'(e[31:0]));
        check("dbz32", 64'(dbz), 64'(e[64]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL done8 unexpected: hi=0x%0h lo=0x%0h", hi8, lo8);
      end else begin
        logic [16:0] e;
        e = q8.pop_front();
        check("hi8", 64'(hi8), 64'(e[15:8]));
        check("lo8", 64'(lo8), 64'(e[7:0]));
        check("dbz8", 64'(dbz8), 64'(e[16]));
      end
    end
  end

  // Returns at the negedge right after the accepting posedge.
  task automatic start_op(input logic [1:0] o, input logic [31:0] ai, input logic [31:0] bi,
                          input logic [64:0] exp, input bit push, input bit hwe);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = ai;
    b     = bi;
    hi_we = hwe;
    wdata = 32'h0000_0099;
    if (push) q32.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_done(input int exp_lat, input string name);
    int lat;
    int busy_cnt;
    lat      = 0;
    busy_cnt = int'(busy);
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      busy_cnt += int'(busy);
    end
    if (exp_lat >= 0) begin
      check({name, " latency"}, 64'(lat), 64'(exp_lat));
      check({name, " busy cycles"}, 64'(busy_cnt), 64'(exp_lat));
    end else begin
      check({name, " done seen"}, 64'(done), 64'(1));
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] ai, input logic [31:0] bi,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                       input int exp_lat, input string name);
    start_op(o, ai, bi, {edbz, ehi, elo}, 1'b1, 1'b0);
    wait_done(exp_lat, name);
  endtask

  initial begin
    #1;
    check("reset hi", 64'(hi), 64'(0));
    check("reset lo", 64'(lo), 64'(0));
    check("reset busy/done/dbz", 64'({busy, done, dbz}), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, "multu max");
    issue(OpMult, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33, "mult -3*5");
    issue(OpMult, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 33, "mult minmin");
    issue(OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, "div -7/2");
    issue(OpDivu, 32'hFFFF_FFF9, 32'd2, 32'h1, 32'h7FFF_FFFC, 1'b0, 33, "divu");
    issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 33, "div overflow");
    issue(OpDiv, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 1'b0, 33, "div 7/-2");
    issue(OpDivu, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, "divu 100/7");

    issue(OpDivu, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1, "divu by zero");
    @(negedge clk);
    check("dbz one-cycle pulse", 64'({done, dbz}), 64'(0));
    issue(OpDiv, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1, 1, "div -8 by zero");
    issue(OpMultu, 32'd1, 32'd1, 32'd0, 32'd1, 1'b0, 33, "multu after dbz");

    // Start and MTLO while busy must be ignored.
    start_op(OpMultu, 32'd3, 32'd4, {1'b0, 32'd0, 32'd12}, 1'b1, 1'b0);
    repeat (9) @(negedge clk);
    start = 1'b1;
    op    = OpDiv;
    a     = 32'd9;
    b     = 32'd0;
    lo_we = 1'b1;
    wdata = 32'hAA;
    @(negedge clk);
    start = 1'b0;
    lo_we = 1'b0;
    wait_done(-1, "busy ignore");

    @(negedge clk);
    lo_we = 1'b1;
    wdata = 32'hAA;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo lo", 64'(lo), 64'h0000_00AA);
    check("mtlo no done", 64'(done), 64'(0));
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'h55;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    check("mthi+mtlo", 64'({hi, lo}), {32'h55, 32'h55});

    // Start together with MTHI: start wins.
    start_op(OpMultu, 32'd2, 32'd2, {1'b0, 32'd0, 32'd4}, 1'b1, 1'b1);
    check("start beats mthi", 64'(hi), 64'h55);
    wait_done(33, "multu 2*2");

    // Reset mid-operation.
    start_op(OpMult, 32'd7, 32'd9, '0, 1'b0, 1'b0);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort hi/lo", 64'({hi, lo}), 64'(0));
    check("abort busy", 64'(busy), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("idle after abort", 64'(busy), 64'(0));
    issue(OpMultu, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 33, "multu 2*3");

    // Width=8 instance.
    begin
      int lat;
      @(negedge clk);
      start8 = 1'b1;
      op8    = OpMultu;
      a8     = 8'hFF;
      b8     = 8'hFF;
      q8.push_back({1'b0, 8'hFE, 8'h01});
      @(negedge clk);
      start8 = 1'b0;
      a8     = 8'h00;
      lat    = 0;
      while (!done8 && lat < 100) begin
        @(negedge clk);
        lat++;
      end
      check("w8 latency", 64'(lat), 64'(9));
    end

    repeat (5) @(negedge clk);
    check("queue32 drained", 64'(q32.size()), 64'(0));
    check("queue8 drained", 64'(q8.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
